instruction_fetch: RTL and testbench

Instruction-fetch stage of the pipelined MIPS core. It holds the program counter, reads the instruction memory, and drives the IF/ID pipeline register consumed by the decode stage, whose opcode field feeds `control_unit`. It also handles PC redirects for branches and jumps, hazard stalls, flushes, and HALT detection. A program-load write port into the instruction memory is provided for the debug unit.

---
 rtl/mips_pkg.sv | 18 +
 rtl/instr_mem.sv | 42 ++++
 rtl/instruction_fetch.sv | 138 +++++++++++++
 tb/tb_instruction_fetch.sv | 185 ++++++++++++++++++
 4 files changed

// File: rtl/mips_pkg.sv
// Shared definitions for the MIPS core: PC-source encodings, special
// instruction words and the fetch-stage FSM encoding.
package mips_pkg;

    localparam logic [1:0] PC_SRC_SEQ    = 2'b00;
    localparam logic [1:0] PC_SRC_BRANCH = 2'b01;
    localparam logic [1:0] PC_SRC_JUMP   = 2'b10;
    localparam logic [1:0] PC_SRC_JR     = 2'b11;

    localparam logic [31:0] HALT_INSTR = 32'hFFFF_FFFF;
    localparam logic [31:0] NOP_INSTR  = 32'h0000_0000;

    typedef enum logic {
        ST_RUN    = 1'b0,
        ST_HALTED = 1'b1
    } fetch_state_e;

endpackage

// File: rtl/instr_mem.sv
// Instruction memory: one synchronous read port, one write port, read-first.
// Only the read data register is reset; the array contents are not.
import mips_pkg::*;

module instr_mem #(
    parameter int NB_DATA = 32,
    parameter int NB_ADDR = 10
) (
    input  logic               i_clock,
    input  logic               i_reset,
    input  logic               i_rd_enb,
    input  logic [NB_ADDR-1:0] i_rd_addr,
    input  logic               i_wr_enb,
    input  logic [NB_ADDR-1:0] i_wr_addr,
    input  logic [NB_DATA-1:0] i_wr_data,
    output logic [NB_DATA-1:0] o_rd_data
);

    localparam int DEPTH = 1 << NB_ADDR;

    logic [NB_DATA-1:0] r_mem [DEPTH];
    logic [NB_DATA-1:0] r_rd_data;

    // Program-load writes, accepted regardless of pipeline state.
    always_ff @(posedge i_clock) begin
        if (i_wr_enb) begin
            r_mem[i_wr_addr] <= i_wr_data;
        end
    end

    // Read register samples the array before this edge's write lands.
    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            r_rd_data <= '0;
        end else if (i_rd_enb) begin
            r_rd_data <= r_mem[i_rd_addr];
        end
    end

    assign o_rd_data = r_rd_data;

endmodule

// File: rtl/instruction_fetch.sv
// Fetch stage: PC register, redirect mux, IF/ID register and HALT detection.
// The instruction half of IF/ID is the instruction memory's read register.
import mips_pkg::*;

module instruction_fetch #(
    parameter int NB_DATA      = 32,
    parameter int NB_IMEM_ADDR = 10
) (
    input  logic                    i_clock,
    input  logic                    i_reset,
    input  logic                    i_enable,
    input  logic                    i_stall,
    input  logic                    i_flush,
    input  logic [1:0]              i_pc_src,
    input  logic [NB_DATA-1:0]      i_branch_target,
    input  logic [NB_DATA-1:0]      i_jump_target,
    input  logic [NB_DATA-1:0]      i_jr_target,
    input  logic                    i_imem_wr_enb,
    input  logic [NB_IMEM_ADDR-1:0] i_imem_wr_addr,
    input  logic [NB_DATA-1:0]      i_imem_wr_data,
    output logic [NB_DATA-1:0]      o_instruction,
    output logic [NB_DATA-1:0]      o_pc_plus4,
    output logic                    o_valid,
    output logic [NB_DATA-1:0]      o_pc,
    output logic                    o_halt
);

    localparam logic [NB_DATA-1:0] PC_STEP    = NB_DATA'(32'd4);
    localparam logic [NB_DATA-1:0] ALIGN_MASK = {{(NB_DATA-2){1'b1}}, 2'b00};

    fetch_state_e       r_state;
    fetch_state_e       w_state_next;
    logic [NB_DATA-1:0] r_pc;
    logic [NB_DATA-1:0] r_pc_plus4;
    logic               r_valid;
    logic [NB_DATA-1:0] w_imem_rdata;
    logic [NB_DATA-1:0] w_pc_plus4;
    logic [NB_DATA-1:0] w_pc_target;
    logic [NB_DATA-1:0] w_pc_next;
    logic [NB_DATA-1:0] w_pc_plus4_next;
    logic               w_valid_next;
    logic               w_halt_pending;
    logic               w_adv;

    instr_mem #(
        .NB_DATA (NB_DATA),
        .NB_ADDR (NB_IMEM_ADDR)
    ) u_instr_mem (
        .i_clock   (i_clock),
        .i_reset   (i_reset),
        .i_rd_enb  (w_adv),
        .i_rd_addr (r_pc[NB_IMEM_ADDR+1:2]),
        .i_wr_enb  (i_imem_wr_enb),
        .i_wr_addr (i_imem_wr_addr),
        .i_wr_data (i_imem_wr_data),
        .o_rd_data (w_imem_rdata)
    );

    assign w_pc_plus4 = r_pc + PC_STEP;

    // Next state; a HALT that is not being squashed freezes fetch immediately.
    always_comb begin
        w_state_next   = r_state;
        w_halt_pending = 1'b0;
        w_adv          = 1'b0;
        case (r_state)
            ST_RUN: begin
                w_halt_pending = i_enable & r_valid & ~i_flush &
                                 (w_imem_rdata == NB_DATA'(HALT_INSTR));
                w_adv          = i_enable & ~i_stall & ~w_halt_pending;
                if (w_halt_pending) begin
                    w_state_next = ST_HALTED;
                end else begin
                    w_state_next = ST_RUN;
                end
            end
            ST_HALTED: begin
                w_state_next = ST_HALTED;
            end
            default: begin
                w_state_next = ST_RUN;
            end
        endcase
    end

    // Redirect mux; stored PC is always word aligned.
    always_comb begin
        w_pc_target = w_pc_plus4;
        case (i_pc_src)
            PC_SRC_SEQ:    w_pc_target = w_pc_plus4;
            PC_SRC_BRANCH: w_pc_target = i_branch_target;
            PC_SRC_JUMP:   w_pc_target = i_jump_target;
            PC_SRC_JR:     w_pc_target = i_jr_target;
            default:       w_pc_target = w_pc_plus4;
        endcase
        w_pc_next = w_pc_target & ALIGN_MASK;
    end

    // IF/ID control: squash (flush or halt) beats stall, stall holds.
    always_comb begin
        w_valid_next    = r_valid;
        w_pc_plus4_next = r_pc_plus4;
        if (!i_enable) begin
            w_valid_next = r_valid;
        end else if ((r_state == ST_HALTED) || w_halt_pending || i_flush) begin
            w_valid_next = 1'b0;
        end else if (w_adv) begin
            w_valid_next    = 1'b1;
            w_pc_plus4_next = w_pc_plus4;
        end else begin
            w_valid_next = r_valid;
        end
    end

    // State, PC and IF/ID registers.
    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            r_state    <= ST_RUN;
            r_pc       <= '0;
            r_pc_plus4 <= '0;
            r_valid    <= 1'b0;
        end else begin
            r_state    <= w_state_next;
            r_valid    <= w_valid_next;
            r_pc_plus4 <= w_pc_plus4_next;
            if (w_adv) begin
                r_pc <= w_pc_next;
            end
        end
    end

    assign o_instruction = r_valid ? w_imem_rdata : NB_DATA'(NOP_INSTR);
    assign o_pc_plus4    = r_pc_plus4;
    assign o_valid       = r_valid;
    assign o_pc          = r_pc;
    assign o_halt        = (r_state == ST_HALTED);

endmodule

// File: tb/tb_instruction_fetch.sv
// Directed bench for instruction_fetch: each step queues its expected IF/ID
// and PC values, then checks them one time unit after the clock edge.
module tb_instruction_fetch;

    logic        i_clock = 1'b0;
    logic        i_reset;
    logic        i_enable;
    logic        i_stall;
    logic        i_flush;
    logic [1:0]  i_pc_src;
    logic [31:0] i_branch_target;
    logic [31:0] i_jump_target;
    logic [31:0] i_jr_target;
    logic        i_imem_wr_enb;
    logic [9:0]  i_imem_wr_addr;
    logic [31:0] i_imem_wr_data;
    logic [31:0] o_instruction;
    logic [31:0] o_pc_plus4;
    logic        o_valid;
    logic [31:0] o_pc;
    logic        o_halt;

    int n_assert = 0;
    int n_fail   = 0;

    typedef struct {
        string       tag;
        logic [31:0] instr;
        logic [31:0] pc4;
        logic [31:0] pc;
        logic        valid;
        logic        halt;
        logic        chk_pc4;
    } exp_t;

    exp_t sb_q[$];

    instruction_fetch #(
        .NB_DATA      (32),
        .NB_IMEM_ADDR (10)
    ) dut (
        .i_clock         (i_clock),
        .i_reset         (i_reset),
        .i_enable        (i_enable),
        .i_stall         (i_stall),
        .i_flush         (i_flush),
        .i_pc_src        (i_pc_src),
        .i_branch_target (i_branch_target),
        .i_jump_target   (i_jump_target),
        .i_jr_target     (i_jr_target),
        .i_imem_wr_enb   (i_imem_wr_enb),
        .i_imem_wr_addr  (i_imem_wr_addr),
        .i_imem_wr_data  (i_imem_wr_data),
        .o_instruction   (o_instruction),
        .o_pc_plus4      (o_pc_plus4),
        .o_valid         (o_valid),
        .o_pc            (o_pc),
        .o_halt          (o_halt)
    );

    always #5 i_clock = ~i_clock;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_assert++;
        assert (obs === exp_v) else begin
            n_fail++;
            $error("FAIL %s: observed %h, expected %h", tag, obs, exp_v);
        end
    endtask

    task automatic step(input string tag, input logic [31:0] e_instr, input logic [31:0] e_pc4,
                        input logic [31:0] e_pc, input logic e_valid, input logic e_halt,
                        input logic e_chk_pc4);
        exp_t e;
        e.tag = tag; e.instr = e_instr; e.pc4 = e_pc4; e.pc = e_pc;
        e.valid = e_valid; e.halt = e_halt; e.chk_pc4 = e_chk_pc4;
        sb_q.push_back(e);
        @(posedge i_clock);
        #1;
        e = sb_q.pop_front();
        chk({e.tag, ".instr"}, o_instruction, e.instr);
        chk({e.tag, ".pc"}, o_pc, e.pc);
        chk({e.tag, ".valid"}, {31'd0, o_valid}, {31'd0, e.valid});
        chk({e.tag, ".halt"}, {31'd0, o_halt}, {31'd0, e.halt});
        if (e.chk_pc4) begin
            chk({e.tag, ".pc4"}, o_pc_plus4, e.pc4);
        end
    endtask

    task automatic defaults();
        i_reset = 1'b0; i_enable = 1'b1; i_stall = 1'b0; i_flush = 1'b0;
        i_pc_src = 2'b00; i_branch_target = 32'd0; i_jump_target = 32'd0;
        i_jr_target = 32'd0; i_imem_wr_enb = 1'b0; i_imem_wr_addr = 10'd0;
        i_imem_wr_data = 32'd0;
    endtask

    logic [9:0]  pre_addr [12];
    logic [31:0] pre_data [12];

    initial begin
        pre_addr = '{10'd0, 10'd1, 10'd2, 10'd3, 10'd16, 10'd17, 10'd18,
                     10'd32, 10'd33, 10'd34, 10'd64, 10'd65};
        pre_data = '{32'h2001_0005, 32'h2002_0007, 32'h0022_1820, 32'hFFFF_FFFF,
                     32'h2003_0010, 32'hFFFF_FFFF, 32'h2004_0012, 32'h2005_0020,
                     32'h1111_1111, 32'h2222_2222, 32'h3333_3333, 32'h4444_4444};
        defaults();
        i_reset = 1'b1;
        for (int k = 0; k < 12; k++) begin
            i_imem_wr_enb = 1'b1; i_imem_wr_addr = pre_addr[k]; i_imem_wr_data = pre_data[k];
            @(posedge i_clock); #1;
        end
        i_imem_wr_addr = 10'd66; i_imem_wr_data = 32'h5555_5555;
        step("reset", 32'd0, 32'd0, 32'd0, 1'b0, 1'b0, 1'b1);

        // Straight-line program ending in HALT
        defaults();
        step("run0", 32'h2001_0005, 32'd4,  32'd4,  1'b1, 1'b0, 1'b1);
        step("run1", 32'h2002_0007, 32'd8,  32'd8,  1'b1, 1'b0, 1'b1);
        step("run2", 32'h0022_1820, 32'd12, 32'd12, 1'b1, 1'b0, 1'b1);
        step("run3", 32'hFFFF_FFFF, 32'd16, 32'd16, 1'b1, 1'b0, 1'b1);
        step("halt", 32'd0, 32'd0, 32'd16, 1'b0, 1'b1, 1'b0);
        step("halt_hold", 32'd0, 32'd0, 32'd16, 1'b0, 1'b1, 1'b0);

        // Reset while halted, with conflicting inputs active
        i_reset = 1'b1; i_stall = 1'b1; i_flush = 1'b1; i_pc_src = 2'b10; i_jump_target = 32'h80;
        step("rst_halted", 32'd0, 32'd0, 32'd0, 1'b0, 1'b0, 1'b1);

        // Stall for two cycles after the first fetch
        defaults();
        step("s_f0", 32'h2001_0005, 32'd4, 32'd4, 1'b1, 1'b0, 1'b1);
        i_stall = 1'b1;
        step("stall1", 32'h2001_0005, 32'd4, 32'd4, 1'b1, 1'b0, 1'b1);
        step("stall2", 32'h2001_0005, 32'd4, 32'd4, 1'b1, 1'b0, 1'b1);
        i_stall = 1'b0;
        step("s_f1", 32'h2002_0007, 32'd8, 32'd8, 1'b1, 1'b0, 1'b1);

        // Taken branch with flush
        i_pc_src = 2'b01; i_branch_target = 32'h40; i_flush = 1'b1;
        step("br_flush", 32'd0, 32'd0, 32'h40, 1'b0, 1'b0, 1'b0);
        defaults();
        step("br_tgt", 32'h2003_0010, 32'h44, 32'h44, 1'b1, 1'b0, 1'b1);

        // HALT on the wrong path, squashed by a jump
        step("wp_halt", 32'hFFFF_FFFF, 32'h48, 32'h48, 1'b1, 1'b0, 1'b1);
        i_pc_src = 2'b10; i_jump_target = 32'h80; i_flush = 1'b1;
        step("jmp_flush", 32'd0, 32'd0, 32'h80, 1'b0, 1'b0, 1'b0);
        defaults();
        step("jmp_tgt", 32'h2005_0020, 32'h84, 32'h84, 1'b1, 1'b0, 1'b1);

        // Disabled for three cycles while the next word is rewritten
        i_enable = 1'b0; i_stall = 1'b1; i_flush = 1'b1; i_pc_src = 2'b11; i_jr_target = 32'h200;
        i_imem_wr_enb = 1'b1; i_imem_wr_addr = 10'd33; i_imem_wr_data = 32'h2006_0021;
        step("dis1", 32'h2005_0020, 32'h84, 32'h84, 1'b1, 1'b0, 1'b1);
        i_imem_wr_enb = 1'b0;
        step("dis2", 32'h2005_0020, 32'h84, 32'h84, 1'b1, 1'b0, 1'b1);
        step("dis3", 32'h2005_0020, 32'h84, 32'h84, 1'b1, 1'b0, 1'b1);
        defaults();
        step("new_word", 32'h2006_0021, 32'h88, 32'h88, 1'b1, 1'b0, 1'b1);

        // Unaligned jr target without flush: wrong-path word stays valid
        i_pc_src = 2'b11; i_jr_target = 32'h103;
        step("jr_wp", 32'h2222_2222, 32'h8C, 32'h100, 1'b1, 1'b0, 1'b1);
        defaults();
        step("jr_tgt", 32'h3333_3333, 32'h104, 32'h104, 1'b1, 1'b0, 1'b1);

        // Stall + flush + redirect together
        i_stall = 1'b1; i_flush = 1'b1; i_pc_src = 2'b01; i_branch_target = 32'h40;
        step("sfr", 32'd0, 32'd0, 32'h104, 1'b0, 1'b0, 1'b0);
        defaults();
        step("sfr_next", 32'h4444_4444, 32'h108, 32'h108, 1'b1, 1'b0, 1'b1);

        // Same-edge read and write of one word returns the old contents
        i_imem_wr_enb = 1'b1; i_imem_wr_addr = 10'd66; i_imem_wr_data = 32'h6666_6666;
        step("rd_first", 32'h5555_5555, 32'h10C, 32'h10C, 1'b1, 1'b0, 1'b1);
        defaults();
        i_pc_src = 2'b10; i_jump_target = 32'h108; i_flush = 1'b1;
        step("back_jmp", 32'd0, 32'd0, 32'h108, 1'b0, 1'b0, 1'b0);
        defaults();
        step("rd_new", 32'h6666_6666, 32'h10C, 32'h10C, 1'b1, 1'b0, 1'b1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
